// File: rtl/uart_sys_pkg.sv
// Shared definitions for the UART command path: decoder state encoding and default opcodes.
package uart_sys_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_TX_SEND
    } cmd_state_e;

    localparam logic [7:0] WR_CMD_DEF = 8'hAA;
    localparam logic [7:0] RD_CMD_DEF = 8'hBB;

endpackage

// File: rtl/uart_rx_cmd_decoder.sv
// Parses write (opcode, address, data) and read (opcode, address) frames from the UART RX byte
// stream, drives register-file strobes and forwards read results to the UART TX.
module uart_rx_cmd_decoder
    import uart_sys_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0] WR_CMD = WR_CMD_DEF,
    parameter logic [DATA_WIDTH-1:0] RD_CMD = RD_CMD_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    output logic                  WR_EN,
    output logic                  RD_EN,
    output logic [ADDR_WIDTH-1:0] ADDRESS,
    output logic [DATA_WIDTH-1:0] WR_DATA,
    input  logic [DATA_WIDTH-1:0] RD_DATA,
    input  logic                  RD_DATA_VLD,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_D_VLD,
    input  logic                  TX_BUSY,
    output logic                  CMD_ERR
);

    cmd_state_e            state_q;
    logic                  wrEn_q;
    logic                  rdEn_q;
    logic                  txVld_q;
    logic                  cmdErr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wrData_q;
    logic [DATA_WIDTH-1:0] txData_q;

    // Strobes default low every cycle so each one is a single-cycle pulse; the case arms
    // only raise them, which also keeps them mutually exclusive by construction.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q  <= ST_IDLE;
            wrEn_q   <= 1'b0;
            rdEn_q   <= 1'b0;
            txVld_q  <= 1'b0;
            cmdErr_q <= 1'b0;
            addr_q   <= '0;
            wrData_q <= '0;
            txData_q <= '0;
        end else begin
            wrEn_q   <= 1'b0;
            rdEn_q   <= 1'b0;
            txVld_q  <= 1'b0;
            cmdErr_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (RX_D_VLD) begin
                        if (RX_P_DATA == WR_CMD) begin
                            state_q <= ST_WR_ADDR;
                        end else if (RX_P_DATA == RD_CMD) begin
                            state_q <= ST_RD_ADDR;
                        end else begin
                            cmdErr_q <= 1'b1;
                        end
                    end
                end
                ST_WR_ADDR: begin
                    if (RX_D_VLD) begin
                        addr_q  <= RX_P_DATA[ADDR_WIDTH-1:0];
                        state_q <= ST_WR_DATA;
                    end
                end
                ST_WR_DATA: begin
                    if (RX_D_VLD) begin
                        wrData_q <= RX_P_DATA;
                        wrEn_q   <= 1'b1;
                        state_q  <= ST_IDLE;
                    end
                end
                ST_RD_ADDR: begin
                    if (RX_D_VLD) begin
                        addr_q  <= RX_P_DATA[ADDR_WIDTH-1:0];
                        rdEn_q  <= 1'b1;
                        state_q <= ST_RD_WAIT;
                    end
                end
                // RX bytes arriving here and in TX_SEND are intentionally ignored.
                ST_RD_WAIT: begin
                    if (RD_DATA_VLD) begin
                        txData_q <= RD_DATA;
                        state_q  <= ST_TX_SEND;
                    end
                end
                ST_TX_SEND: begin
                    if (!TX_BUSY) begin
                        txVld_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign WR_EN     = wrEn_q;
    assign RD_EN     = rdEn_q;
    assign TX_D_VLD  = txVld_q;
    assign CMD_ERR   = cmdErr_q;
    assign ADDRESS   = addr_q;
    assign WR_DATA   = wrData_q;
    assign TX_P_DATA = txData_q;

endmodule

// File: tb/tb_uart_rx_cmd_decoder.sv
// Randomised scoreboard bench: a byte-level frame model predicts strobe events and a
// negedge monitor pops and compares them as the decoder produces them.
module tb_uart_rx_cmd_decoder;

    localparam logic [7:0] OP_WR = 8'hAA;
    localparam logic [7:0] OP_RD = 8'hBB;

    localparam int EV_WR  = 0;
    localparam int EV_RD  = 1;
    localparam int EV_TX  = 2;
    localparam int EV_ERR = 3;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] RX_P_DATA = 8'h00;
    logic       RX_D_VLD = 1'b0;
    logic       WR_EN;
    logic       RD_EN;
    logic [3:0] ADDRESS;
    logic [7:0] WR_DATA;
    logic [7:0] RD_DATA = 8'h00;
    logic       RD_DATA_VLD = 1'b0;
    logic [7:0] TX_P_DATA;
    logic       TX_D_VLD;
    logic       TX_BUSY = 1'b0;
    logic       CMD_ERR;

    typedef struct {
        int         kind;
        logic [3:0] addr;
        logic [7:0] data;
    } evt_t;

    evt_t       expQ[$];
    logic [7:0] pend[$];
    logic [7:0] dropQ[$];
    bit         dropMode = 1'b0;
    int         total = 0;
    int         bad = 0;
    int         monN;
    int         actKind;
    evt_t       monEvt;

    uart_rx_cmd_decoder dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_P_DATA   (RX_P_DATA),
        .RX_D_VLD    (RX_D_VLD),
        .WR_EN       (WR_EN),
        .RD_EN       (RD_EN),
        .ADDRESS     (ADDRESS),
        .WR_DATA     (WR_DATA),
        .RD_DATA     (RD_DATA),
        .RD_DATA_VLD (RD_DATA_VLD),
        .TX_P_DATA   (TX_P_DATA),
        .TX_D_VLD    (TX_D_VLD),
        .TX_BUSY     (TX_BUSY),
        .CMD_ERR     (CMD_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pushEvt(input int kind, input logic [3:0] addr, input logic [7:0] data);
        evt_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        expQ.push_back(e);
    endtask

    // Frame-level reference: collect bytes of the current frame, emit an event when it completes.
    task automatic modelByte(input logic [7:0] b);
        logic [7:0] op;
        logic [7:0] a;
        if (dropMode) return;
        if (pend.size() == 0) begin
            if (b == OP_WR || b == OP_RD) pend.push_back(b);
            else pushEvt(EV_ERR, 4'h0, 8'h00);
        end else begin
            op = pend[0];
            if (op == OP_WR) begin
                if (pend.size() == 1) begin
                    pend.push_back(b);
                end else begin
                    a = pend[1];
                    pushEvt(EV_WR, a[3:0], b);
                    pend.delete();
                end
            end else begin
                pushEvt(EV_RD, b[3:0], 8'h00);
                pend.delete();
                dropMode = 1'b1;
            end
        end
    endtask

    // All stimulus tasks start and end right at a falling edge.
    task automatic sendByte(input logic [7:0] b);
        modelByte(b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        @(negedge CLK);
        RX_D_VLD  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            RD_DATA_VLD = 1'($urandom_range(0, 1));
            RD_DATA     = 8'($urandom);
            @(negedge CLK);
            RD_DATA_VLD = 1'b0;
        end
    endtask

    function automatic logic [7:0] randByte();
        int r;
        r = $urandom_range(0, 7);
        if (r == 0) return OP_WR;
        if (r == 1) return OP_RD;
        return 8'($urandom);
    endfunction

    task automatic writeFrame(input logic [7:0] a, input logic [7:0] d, input int maxGap);
        sendByte(OP_WR);
        idle($urandom_range(0, maxGap));
        sendByte(a);
        idle($urandom_range(0, maxGap));
        sendByte(d);
    endtask

    task automatic readFrame(input logic [7:0] a, input int lat, input logic [7:0] d, input int busyCycles);
        int waited;
        sendByte(OP_RD);
        sendByte(a);
        pushEvt(EV_TX, 4'h0, d);
        waited = 0;
        while (!RD_EN && waited < 4) begin
            @(negedge CLK);
            waited++;
        end
        checkOutput("rdEnSeen", 32'(RD_EN), 32'd1);
        for (int k = 0; k < lat - 1; k++) begin
            if (dropQ.size() > 0) sendByte(dropQ.pop_front());
            else @(negedge CLK);
        end
        RD_DATA     = d;
        RD_DATA_VLD = 1'b1;
        TX_BUSY     = (busyCycles > 0);
        @(negedge CLK);
        RD_DATA_VLD = 1'b0;
        for (int k = 0; k < busyCycles; k++) begin
            if ($urandom_range(0, 3) == 0) sendByte(randByte());
            else @(negedge CLK);
            checkOutput("txLowWhileBusy", 32'(TX_D_VLD), 32'd0);
            checkOutput("txDataHeld", 32'(TX_P_DATA), 32'(d));
        end
        TX_BUSY = 1'b0;
        @(negedge CLK);
        checkOutput("txPulseTiming", 32'(TX_D_VLD), 32'd1);
        dropMode = 1'b0;
        dropQ.delete();
    endtask

    task automatic doReset();
        RST = 1'b0;
        pend.delete();
        dropMode = 1'b0;
        @(negedge CLK);
        checkOutput("rstAddress", 32'(ADDRESS), 32'd0);
        checkOutput("rstWrData", 32'(WR_DATA), 32'd0);
        checkOutput("rstTxData", 32'(TX_P_DATA), 32'd0);
        checkOutput("rstStrobes", 32'({WR_EN, RD_EN, TX_D_VLD, CMD_ERR}), 32'd0);
        RST = 1'b1;
    endtask

    task automatic applyStimulus();
        logic [7:0] bop;
        int         lat;
        repeat (3) @(negedge CLK);
        checkOutput("resetWrEn", 32'(WR_EN), 32'd0);
        checkOutput("resetRdEn", 32'(RD_EN), 32'd0);
        checkOutput("resetTxVld", 32'(TX_D_VLD), 32'd0);
        checkOutput("resetCmdErr", 32'(CMD_ERR), 32'd0);
        checkOutput("resetAddress", 32'(ADDRESS), 32'd0);
        checkOutput("resetWrData", 32'(WR_DATA), 32'd0);
        checkOutput("resetTxData", 32'(TX_P_DATA), 32'd0);
        RST = 1'b1;
        @(negedge CLK);

        writeFrame(8'h05, 8'h3C, 0);
        idle(2);
        readFrame(8'h07, 3, 8'h5A, 0);
        idle(1);
        readFrame(8'h07, 3, 8'h5A, 20);
        sendByte(8'h12);
        sendByte(OP_WR);
        sendByte(OP_RD);
        sendByte(OP_WR);
        dropQ.push_back(OP_WR);
        dropQ.push_back(8'h01);
        readFrame(8'hF3, 3, 8'hC6, 0);
        idle(3);

        sendByte(OP_WR);
        sendByte(8'h05);
        doReset();
        sendByte(8'h3C);
        idle(2);

        sendByte(OP_WR);
        sendByte(8'h05);
        RX_P_DATA = 8'h3C;
        RX_D_VLD  = 1'b1;
        RST       = 1'b0;
        pend.delete();
        @(negedge CLK);
        RX_D_VLD  = 1'b0;
        checkOutput("pendingStrobeCleared", 32'(WR_EN), 32'd0);
        checkOutput("pendingAddrCleared", 32'(ADDRESS), 32'd0);
        RST = 1'b1;
        idle(1);

        for (int f = 0; f < 60; f++) begin
            case ($urandom_range(0, 3))
                0, 1: writeFrame(randByte(), randByte(), 2);
                2: begin
                    lat = $urandom_range(1, 5);
                    for (int k = 0; k < lat - 1; k++)
                        if ($urandom_range(0, 1) == 1) dropQ.push_back(randByte());
                    readFrame(randByte(), lat, 8'($urandom),
                              ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : 0);
                end
                default: begin
                    do bop = 8'($urandom); while (bop == OP_WR || bop == OP_RD);
                    sendByte(bop);
                end
            endcase
            idle($urandom_range(0, 2));
        end
        idle(10);
        checkOutput("pendingEvents", 32'(expQ.size()), 32'd0);
    endtask

    // Monitor: every strobe must match the oldest predicted event.
    always @(negedge CLK) begin
        if (RST) begin
            monN = int'(WR_EN) + int'(RD_EN) + int'(TX_D_VLD) + int'(CMD_ERR);
            if (monN > 1) checkOutput("strobeExclusive", 32'(monN), 32'd1);
            if (monN >= 1) begin
                actKind = WR_EN ? EV_WR : RD_EN ? EV_RD : TX_D_VLD ? EV_TX : EV_ERR;
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpectedStrobe: got kind %0d expected none at %0t", actKind, $time);
                end else begin
                    monEvt = expQ.pop_front();
                    checkOutput("strobeKind", 32'(actKind), 32'(monEvt.kind));
                    if (monEvt.kind == EV_WR) begin
                        checkOutput("wrAddress", 32'(ADDRESS), 32'(monEvt.addr));
                        checkOutput("wrData", 32'(WR_DATA), 32'(monEvt.data));
                    end else if (monEvt.kind == EV_RD) begin
                        checkOutput("rdAddress", 32'(ADDRESS), 32'(monEvt.addr));
                    end else if (monEvt.kind == EV_TX) begin
                        checkOutput("txData", 32'(TX_P_DATA), 32'(monEvt.data));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
